// File: rtl/ql_mem_sched.sv
// Bus-phase scheduler and single-port SDRAM arbiter for the QL core.
// Owns slot timing, the speed-dependent CPU slot enable, and the CPU/DMA share of the SDRAM port.
module ql_mem_sched #(
  parameter int SLOT_LEN = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  speed,
  input  logic        cpu_ram,
  input  logic        cpu_wr,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_ds,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [23:0] dma_addr,
  input  logic [15:0] dma_din,
  input  logic [1:0]  dma_ds,
  output logic        ce_p,
  output logic        ce_n,
  output logic        cpu_cycle,
  output logic        dma_ack,
  output logic [15:0] dma_dout,
  output logic        sdram_sync,
  output logic [23:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic [1:0]  sdram_ds,
  output logic        sdram_we,
  output logic        sdram_oe,
  input  logic [15:0] sdram_dout
);
  localparam int PW = $clog2(SLOT_LEN);
  localparam logic [PW-1:0] PH_LAST = PW'(SLOT_LEN - 1);
  localparam logic [PW-1:0] PH_CAPT = PW'(SLOT_LEN - 2);
  localparam logic [PW-1:0] PH_NEG  = PW'(4);

  typedef enum logic {IDLE, DMA_BUSY} state_t;
  state_t state, state_next;

  logic [PW-1:0] phase;
  logic [1:0]    slot;
  logic          sub;
  logic [1:0]    spd;
  logic          slot_start, frame_start, live_start;
  logic [1:0]    spd_now;
  logic          own_cpu, grant_dma;
  logic [23:0]   dec_addr, hold_addr;
  logic [15:0]   dec_din, hold_din;
  logic [1:0]    dec_ds, hold_ds;
  logic          dec_we, dec_oe, hold_we, hold_oe, hold_cpu;
  logic [15:0]   dout_q;

  assign slot_start  = (phase == '0);
  assign frame_start = slot_start && (slot == 2'd0);
  assign live_start  = slot_start && !reset;
  assign spd_now     = frame_start ? speed : spd;

  // Ownership is decided live at phase 0 and then frozen in the hold registers for the rest of the slot.
  always_comb begin
    own_cpu = 1'b0;
    case (spd_now)
      2'd0:    own_cpu = (slot == 2'd0) && sub;
      2'd1:    own_cpu = (slot == 2'd0) || (slot == 2'd2);
      default: own_cpu = (slot != 2'd3) || !dma_req;
    endcase
  end

  assign grant_dma = !own_cpu && dma_req;
  assign dec_addr  = own_cpu ? cpu_addr : dma_addr;
  assign dec_din   = own_cpu ? cpu_din  : dma_din;
  assign dec_ds    = own_cpu ? cpu_ds   : dma_ds;
  assign dec_we    = own_cpu ? (cpu_ram && cpu_wr)  : (grant_dma && dma_wr);
  assign dec_oe    = own_cpu ? (cpu_ram && !cpu_wr) : (grant_dma && !dma_wr);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      phase <= '0;
      slot  <= 2'd0;
      sub   <= 1'b0;
      spd   <= 2'd0;
    end else begin
      phase <= phase + 1'b1;
      if (phase == PH_LAST) begin
        slot <= slot + 2'd1;
        if (slot == 2'd3) sub <= !sub;
      end
      if (frame_start) spd <= speed;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_cpu  <= 1'b0;
      hold_addr <= '0;
      hold_din  <= '0;
      hold_ds   <= '0;
      hold_we   <= 1'b0;
      hold_oe   <= 1'b0;
    end else if (slot_start) begin
      hold_cpu  <= own_cpu;
      hold_addr <= dec_addr;
      hold_din  <= dec_din;
      hold_ds   <= dec_ds;
      hold_we   <= dec_we;
      hold_oe   <= dec_oe;
    end
  end

  // Capture one clock early so read data is already valid on the ack clock.
  always_ff @(posedge clk_sys) begin
    if (reset) dout_q <= '0;
    else if (state == DMA_BUSY && phase == PH_CAPT && hold_oe) dout_q <= sdram_dout;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (slot_start && grant_dma) state_next = DMA_BUSY;
      DMA_BUSY: if (phase == PH_LAST) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign ce_p       = live_start;
  assign ce_n       = (phase == PH_NEG) && !reset;
  assign sdram_sync = live_start;
  assign cpu_cycle  = live_start ? own_cpu  : hold_cpu;
  assign sdram_addr = live_start ? dec_addr : hold_addr;
  assign sdram_din  = live_start ? dec_din  : hold_din;
  assign sdram_ds   = live_start ? dec_ds   : hold_ds;
  assign sdram_we   = live_start ? dec_we   : hold_we;
  assign sdram_oe   = live_start ? dec_oe   : hold_oe;
  assign dma_ack    = (state == DMA_BUSY) && (phase == PH_LAST) && !reset;
  assign dma_dout   = dout_q;
endmodule
